// File: rtl/muldiv_pkg.sv
// Shared M-extension definitions for the iterative multiply/divide sequencer.
// Build option MULDIV_FAST_MUL_EN (see muldiv_sequencer) selects a single-cycle multiplier.
package muldiv_pkg;
  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  // neg_q: negate product/quotient; neg_r: negate remainder
  typedef struct packed {
    logic [2:0] funct3;
    logic       neg_q;
    logic       neg_r;
  } op_t;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// acc holds {hi, lo}: product/multiplier for multiply, remainder/quotient for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_nxt
);
  logic [XLEN:0] add_sum, rem_sh, sub_diff;

  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // partial remainder shifted left with the next dividend bit; needs XLEN+1 bits
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    sub_diff = rem_sh - {1'b0, operand};
    if (!is_div)
      acc_nxt = {add_sum, acc[XLEN-1:1]};
    else if (!sub_diff[XLEN])
      acc_nxt = {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// RV M-extension multiply/divide sequencer: IDLE -> CALC (XLEN steps) -> DONE.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_valid,
  input  logic            i_res_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_t            state, state_nxt;
  op_t               op_q, op_in;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, step_out, mul_full;
  logic [XLEN-1:0]   opb, result_q, rs1_abs, rs2_abs, fast_res;
  logic              rs1_neg, rs2_neg, accept, div0, ovf, fast_mul, fast;

  function automatic logic [XLEN-1:0] fixup(input op_t op, input logic [2*XLEN-1:0] a);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r;
    p = op.neg_q ? -a : a;
    q = op.neg_q ? -a[XLEN-1:0] : a[XLEN-1:0];
    r = op.neg_r ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
    if (!op.funct3[2]) return (op.funct3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    return op.funct3[1] ? r : q;
  endfunction

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_q.funct3[2]),
    .acc     (acc),
    .operand (opb),
    .acc_nxt (step_out)
  );

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = !i_funct3[2];
  assign mul_full = {{XLEN{1'b0}}, rs1_abs} * {{XLEN{1'b0}}, rs2_abs};
`else
  assign fast_mul = 1'b0;
  assign mul_full = '0;
`endif

  always_comb begin
    rs1_neg = rs1_signed(i_funct3) & i_rs1[XLEN-1];
    rs2_neg = rs2_signed(i_funct3) & i_rs2[XLEN-1];
    rs1_abs = rs1_neg ? -i_rs1 : i_rs1;
    rs2_abs = rs2_neg ? -i_rs2 : i_rs2;
    op_in   = '{funct3: i_funct3, neg_q: rs1_neg ^ rs2_neg, neg_r: rs1_neg};
    accept  = (state == IDLE) && i_valid && !i_flush;
    div0    = i_funct3[2] && (i_rs2 == '0);
    ovf     = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
              (i_rs1 == INT_MIN) && (i_rs2 == '1);
    fast    = div0 || ovf || fast_mul;
    if (div0)     fast_res = i_funct3[1] ? i_rs1 : '1;
    else if (ovf) fast_res = i_funct3[1] ? '0 : INT_MIN;
    else          fast_res = fixup(op_in, mul_full);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (i_flush) state_nxt = IDLE;
               else if (cnt == LAST) state_nxt = DONE;
      DONE:    if (i_flush || i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          op_q <= op_in;
          cnt  <= '0;
          acc  <= {{XLEN{1'b0}}, rs1_abs};
          opb  <= rs2_abs;
          if (fast) result_q <= fast_res;
        end
        CALC: begin
          acc <= step_out;
          cnt <= cnt + CNT_W'(1);
          // sign fixup folded into the final step so DONE presents a stable result
          if (cnt == LAST) result_q <= fixup(op_q, step_out);
        end
        default: ;
      endcase
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_busy   = (state != IDLE);
  assign o_result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, handshake/flush/reset
// scenarios and randomized ops against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_flush = 1'b0, i_res_ready = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_rs1 = '0, i_rs2 = '0;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_result;
  int tests = 0, fails = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_funct3(i_funct3),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush), .o_ready(o_ready),
    .o_valid(o_valid), .i_res_ready(i_res_ready), .o_result(o_result), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      F3_MULHSU: begin p = 64'(sa * longint'({32'h0, b})); return p[63:32]; end
      F3_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      F3_DIV:    begin if (b == 0) return '1; if (ov) return a; return 32'(sa / sb); end
      F3_DIVU:   begin if (b == 0) return '1; return a / b; end
      F3_REM:    begin if (b == 0) return a; if (ov) return '0; return 32'(sa % sb); end
      default:   begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, hold i_valid with junk while busy, wait for result, then retire it.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit got);
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b;
    @(posedge i_clk); #1;
    i_rs1 = $urandom; i_rs2 = $urandom; i_funct3 = 3'($urandom_range(0, 7));
    lat = 1;
    while (!o_valid && lat < 100) begin @(posedge i_clk); #1; lat++; end
    got = o_valid;
    res = o_result;
    @(negedge i_clk);
    i_valid = 1'b0; i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    i_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h0) begin
      fails++;
      $display("FAIL reset: ready=%b valid=%b busy=%b result=%h, want 1 0 0 00000000",
               o_ready, o_valid, o_busy, o_result);
    end
    @(negedge i_clk); i_rst_n = 1'b1;
  endtask

  typedef struct {logic [2:0] f3; logic [31:0] a, b, exp; int lat;} vec_t;

  task automatic test_directed();
    vec_t v[11];
    logic [31:0] r; int lat; bit got;
    v = '{'{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT},
          '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT},
          '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT},
          '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT},
          '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33},
          '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33},
          '{F3_DIVU,   32'd100,        32'd7,         32'd14,        33},
          '{F3_REMU,   32'd100,        32'd7,         32'd2,         33},
          '{F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1},
          '{F3_REM,    32'd5,          32'd0,         32'd5,         1},
          '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1}};
    for (int i = 0; i < 11; i++) begin
      do_op(v[i].f3, v[i].a, v[i].b, r, lat, got);
      tests++;
      if (!got || r !== v[i].exp || lat !== v[i].lat) begin
        fails++;
        $display("FAIL directed[%0d] f3=%0d a=%h b=%h: got valid=%b result=%h cycle=%0d, want %h cycle=%0d",
                 i, v[i].f3, v[i].a, v[i].b, got, r, lat, v[i].exp, v[i].lat);
      end
    end
    do_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, got);
    tests++;
    if (!got || r !== 32'h0 || lat !== 1) begin
      fails++;
      $display("FAIL rem_overflow: result=%h cycle=%0d, want 00000000 cycle=1", r, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, e; logic [2:0] f3; int lat; bit got;
    for (int i = 0; i < 48; i++) begin
      f3 = 3'($urandom_range(0, 7)); a = rnd_op(); b = rnd_op();
      e = ref_model(f3, a, b);
      do_op(f3, a, b, r, lat, got);
      tests++;
      if (!got || r !== e || lat !== ref_lat(f3, a, b)) begin
        fails++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h: result=%h cycle=%0d, want %h cycle=%0d",
                 i, f3, a, b, r, lat, e, ref_lat(f3, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0; int n;
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = F3_DIVU; i_rs1 = 32'd100; i_rs2 = 32'd7;
    @(posedge i_clk); #1; i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 100) begin @(posedge i_clk); #1; n++; end
    r0 = o_result;
    tests++;
    if (!o_valid || r0 !== 32'd14) begin
      fails++; $display("FAIL hold_first: valid=%b result=%h, want 1 0000000e", o_valid, r0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      tests++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'd14) begin
        fails++;
        $display("FAIL hold[%0d]: valid=%b ready=%b result=%h, want 1 0 0000000e", i, o_valid, o_ready, o_result);
      end
    end
    @(negedge i_clk);
    i_res_ready = 1'b1; i_valid = 1'b1; i_funct3 = F3_MULHU; i_rs1 = 32'hFFFF_FFFF; i_rs2 = 32'd2;
    @(posedge i_clk); #1; i_res_ready = 1'b0;
    tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      fails++; $display("FAIL retire: valid=%b ready=%b, want 0 1", o_valid, o_ready);
    end
    @(posedge i_clk); #1; i_valid = 1'b0;
    tests++;
    if (o_busy !== 1'b1) begin
      fails++; $display("FAIL b2b_accept: busy=%b, want 1", o_busy);
    end
    n = 0;
    while (!o_valid && n < 100) begin @(posedge i_clk); #1; n++; end
    tests++;
    if (!o_valid || o_result !== 32'd1) begin
      fails++; $display("FAIL b2b_result: valid=%b result=%h, want 1 00000001", o_valid, o_result);
    end
    @(negedge i_clk); i_res_ready = 1'b1;
    @(posedge i_clk); #1; i_res_ready = 1'b0;
  endtask

  task automatic test_flush();
    int nv;
    logic [31:0] r; int lat; bit got;
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = F3_DIVU; i_rs1 = $urandom; i_rs2 = 32'd3;
    @(posedge i_clk); #1; i_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    @(negedge i_clk); i_flush = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0;
    tests++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
      fails++; $display("FAIL flush_calc: ready=%b busy=%b valid=%b, want 1 0 0", o_ready, o_busy, o_valid);
    end
    nv = 0;
    repeat (40) begin @(posedge i_clk); #1; if (o_valid) nv++; end
    tests++;
    if (nv !== 0) begin fails++; $display("FAIL flush_no_result: valid cycles=%0d, want 0", nv); end
    @(negedge i_clk); i_valid = 1'b1; i_flush = 1'b1; i_funct3 = F3_DIVU; i_rs2 = 32'd3;
    @(posedge i_clk); #1; i_valid = 1'b0; i_flush = 1'b0;
    tests++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      fails++; $display("FAIL flush_idle_block: ready=%b busy=%b, want 1 0", o_ready, o_busy);
    end
    do_op(F3_REMU, 32'd1000, 32'd7, r, lat, got);
    tests++;
    if (!got || r !== 32'd6 || lat !== 33) begin
      fails++; $display("FAIL flush_recover: result=%h cycle=%0d, want 00000006 cycle=33", r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; bit got;
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = F3_DIV; i_rs1 = 32'hFFFF_FF00; i_rs2 = 32'd5;
    @(posedge i_clk); #1; i_valid = 1'b0;
    repeat (19) @(posedge i_clk);
    @(negedge i_clk); #2; i_rst_n = 1'b0; #1;
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: ready=%b valid=%b busy=%b result=%h, want 1 0 0 00000000",
               o_ready, o_valid, o_busy, o_result);
    end
    @(negedge i_clk); i_rst_n = 1'b1;
    do_op(F3_DIV, 32'hFFFF_FF00, 32'd5, r, lat, got);
    tests++;
    if (!got || r !== 32'hFFFF_FFCD || lat !== 33) begin
      fails++; $display("FAIL reset_recover: result=%h cycle=%0d, want ffffffcd cycle=33", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > XLEN.
REQ-003 i_clk  in  1  sole clock, rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_valid  in  1  request valid (OPCODE_R with funct7 = 7'h01).
REQ-006 i_funct3  in  3  M-ext op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 i_rs1, i_rs2  in  XLEN  operands.
REQ-008 i_flush  in  1  abort in-flight op (branch mispredict/trap).
REQ-009 o_ready  out  1  request accept possible.
REQ-010 o_valid  out  1  result valid.
REQ-011 i_res_ready  in  1  consumer accepts result.
REQ-012 o_result  out  XLEN  result.
REQ-013 o_busy  out  1  stall request to pipeline; high when not IDLE.

Function
REQ-014 FSM states IDLE, CALC, DONE; o_ready = (state == IDLE).
REQ-015 IDLE -> CALC on i_valid && o_ready: latch funct3, |rs1|, |rs2| per signedness, result sign flags, counter = 0.
REQ-016 Signedness: MULH/DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; others unsigned.
REQ-017 CALC: one radix-2 step per cycle (shift-add multiply into 2*XLEN accumulator; restoring shift-subtract divide); counter +1 per cycle; CALC -> DONE after exactly XLEN steps.
REQ-018 Nominal latency: accept edge at cycle 0, o_valid high from cycle XLEN+1.
REQ-019 Sign fixup applied on CALC -> DONE edge; o_result registered, stable while o_valid.
REQ-020 MUL returns low XLEN bits; MULH/MULHSU/MULHU high XLEN bits.
REQ-021 Divide by zero: quotient all-ones, remainder = rs1; IDLE -> DONE directly (o_valid at cycle 1).
REQ-022 Signed overflow (rs1 = 0x8000_0000, rs2 = -1, DIV/REM): quotient 0x8000_0000, remainder 0; fast path as REQ-021.
REQ-023 Remainder sign = dividend sign; quotient negated when operand signs differ (non-zero divisor).
REQ-024 DONE: o_valid held until i_res_ready; DONE -> IDLE on o_valid && i_res_ready; no new accept same cycle.
REQ-025 i_flush in CALC or DONE -> IDLE next edge, o_valid low next cycle, result discarded; i_flush in IDLE blocks acceptance that cycle; flush wins over simultaneous i_res_ready.
REQ-026 i_valid ignored while o_ready low; operand changes after acceptance have no effect.

Reset
REQ-027 Async assert of i_rst_n: state IDLE, o_valid 0, o_result 0, counter 0, accumulators 0; o_ready 1, o_busy 0.
REQ-028 Reset mid-CALC abandons op; first accept possible on first edge after deassertion.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN: defined -> MUL/MULH/MULHSU/MULHU computed by single-cycle combinational multiplier, IDLE -> DONE, o_valid at cycle 1; undefined -> iterative per REQ-017. Divide path iterative in both builds.

Structure
REQ-030 Shared package (muldiv_pkg) SHALL hold funct3 M-ext localparams, OPCODE_R, FUNCT7_MULDIV = 7'h01, and state enum type.
REQ-031 One sub-module, muldiv_step, SHALL implement a single combinational shift-add/shift-subtract step; FSM and sign handling remain in muldiv_sequencer.

Verification
REQ-032 MUL rs1 = 7, rs2 = -3 -> o_result 0xFFFF_FFEB, o_valid at cycle 33 (1 with MULDIV_FAST_MUL_EN).
REQ-033 MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU -1 x 0xFFFF_FFFF -> 0xFFFF_FFFF.
REQ-034 DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-035 DIV 5/0 -> 0xFFFF_FFFF at cycle 1; REM 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
REQ-036 i_res_ready low 5 cycles after o_valid -> o_result held, o_ready low; then accepted, back-to-back request accepted one cycle later.
REQ-037 i_flush at cycle 10 of CALC -> IDLE, no o_valid; i_rst_n pulse at cycle 20 of CALC -> all outputs per REQ-027 immediately.
